data_memory_initiator: RTL and testbench

- Master-side access controller that drives the DataMemory port (mem_write, mem_read, endereco, valor_escrita, valor_saida) on behalf of a client.
- Accepts single or burst load/store requests over a valid/ready handshake and streams write data in.
- Sequences the memory control signals and returns read data as a pulsed stream.
- Sits between the datapath's load/store logic and DataMemory.

---
 rtl/data_memory_initiator.sv | 145 ++++++++++++++
 tb/tb_data_memory_initiator.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_initiator.sv
// data_memory_initiator
//   Master-side access controller for the DataMemory port. It accepts single
//   or burst load/store requests over a valid/ready handshake. For a store it
//   streams the write beats into memory. For a load it returns the words read
//   from memory as a pulsed, registered stream.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   req_*                 request channel (valid/ready, direction, start, len-1)
//   wr_valid/ready/data   write-data beats for store bursts
//   rd_valid/data/last    read beats for load bursts (one-cycle pulses)
//   busy, done            status; done pulses once per completed burst
//   mem_write, mem_read,
//   endereco, valor_escrita,
//   valor_saida           DataMemory port (memory writes on clk edge)
module data_memory_initiator #(
    parameter int ADDR_WIDTH   = 6,
    parameter int DATA_WIDTH   = 8,
    parameter int LEN_WIDTH    = 3,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LEN_WIDTH-1:0]  req_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_write,
    output logic                  mem_read,
    output logic [ADDR_WIDTH-1:0] endereco,
    output logic [DATA_WIDTH-1:0] valor_escrita,
    input  logic [DATA_WIDTH-1:0] valor_saida
);

    localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [LEN_WIDTH-1:0]  beats;
    logic [LAT_W-1:0]      lat_cnt;
    logic                  last_beat;
    logic                  lat_hit;

    assign last_beat = (beats == '0);
    assign lat_hit   = (lat_cnt == LAT_W'(READ_LATENCY - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // The memory controls are decoded purely from state. Because of that, an
    // asynchronous reset drops them in the same cycle.
    always_comb begin
        state_nxt     = state;
        req_ready     = 1'b0;
        wr_ready      = 1'b0;
        mem_write     = 1'b0;
        mem_read      = 1'b0;
        endereco      = '0;
        valor_escrita = '0;
        busy          = 1'b1;
        done          = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) state_nxt = req_write ? WRITE : READ;
            end
            WRITE: begin
                wr_ready      = 1'b1;
                mem_write     = wr_valid;
                endereco      = cur_addr;
                valor_escrita = wr_data;
                if (wr_valid && last_beat) state_nxt = DONE;
            end
            READ: begin
                mem_read = 1'b1;
                endereco = cur_addr;
                if (lat_hit && last_beat) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath registers. The direction of a burst is carried by the
    // WRITE/READ state itself, so it needs no separate flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_addr <= '0;
            beats    <= '0;
            lat_cnt  <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            case (state)
                IDLE: begin
                    lat_cnt <= '0;
                    if (req_valid) begin
                        cur_addr <= req_addr;
                        beats    <= req_len;
                    end
                end
                WRITE: begin
                    if (wr_valid) begin
                        cur_addr <= cur_addr + 1'b1;
                        if (!last_beat) beats <= beats - 1'b1;
                    end
                end
                READ: begin
                    if (lat_hit) begin
                        rd_data  <= valor_saida;
                        rd_valid <= 1'b1;
                        rd_last  <= last_beat;
                        cur_addr <= cur_addr + 1'b1;
                        lat_cnt  <= '0;
                        if (!last_beat) beats <= beats - 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_initiator.sv
module tb_data_memory_initiator;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid, req_write, wr_valid;
    logic [5:0] req_addr;
    logic [2:0] req_len;
    logic [7:0] wr_data;
    int         sel;   // 0: READ_LATENCY=1 instance, 1: READ_LATENCY=2 instance

    logic [1:0] req_ready_d, wr_ready_d, rd_valid_d, rd_last_d, busy_d, done_d;
    logic [1:0] mem_write_d, mem_read_d, req_valid_d;
    logic [7:0] rd_data_d [2];
    logic [5:0] endereco_d [2];
    logic [7:0] valor_escrita_d [2];
    logic [7:0] valor_saida_d [2];
    logic [7:0] mem [2][64];

    logic [7:0] ref_mem [2][64];
    logic [7:0] wq [$];
    int chk_cnt = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        assign req_valid_d[g] = req_valid && (sel == g);
        data_memory_initiator #(.ADDR_WIDTH(6), .DATA_WIDTH(8), .LEN_WIDTH(3),
                                .READ_LATENCY(g + 1)) dut (
            .clk(clk), .reset(reset),
            .req_valid(req_valid_d[g]), .req_ready(req_ready_d[g]),
            .req_write(req_write), .req_addr(req_addr), .req_len(req_len),
            .wr_valid(wr_valid), .wr_ready(wr_ready_d[g]), .wr_data(wr_data),
            .rd_valid(rd_valid_d[g]), .rd_data(rd_data_d[g]), .rd_last(rd_last_d[g]),
            .busy(busy_d[g]), .done(done_d[g]),
            .mem_write(mem_write_d[g]), .mem_read(mem_read_d[g]),
            .endereco(endereco_d[g]), .valor_escrita(valor_escrita_d[g]),
            .valor_saida(valor_saida_d[g]));
        // DataMemory model: synchronous write, combinational read
        always @(posedge clk) if (mem_write_d[g]) mem[g][endereco_d[g]] <= valor_escrita_d[g];
        assign valor_saida_d[g] = mem[g][endereco_d[g]];
    end

    logic       o_req_ready, o_wr_ready, o_rd_valid, o_rd_last, o_busy, o_done, o_mem_write, o_mem_read;
    logic [7:0] o_rd_data;
    logic [5:0] o_endereco;
    assign o_req_ready = req_ready_d[sel];
    assign o_wr_ready  = wr_ready_d[sel];
    assign o_rd_valid  = rd_valid_d[sel];
    assign o_rd_last   = rd_last_d[sel];
    assign o_busy      = busy_d[sel];
    assign o_done      = done_d[sel];
    assign o_mem_write = mem_write_d[sel];
    assign o_mem_read  = mem_read_d[sel];
    assign o_rd_data   = rd_data_d[sel];
    assign o_endereco  = endereco_d[sel];

    task automatic do_store(input logic [5:0] a, input int len, input int stall_pct, input int gap);
        int i, t, stalls, g;
        logic [5:0] ea;
        chk_cnt++;
        if (o_req_ready !== 1'b1) $display("FAIL store_req_ready: got %b exp 1", o_req_ready);
        else pass_cnt++;
        req_valid = 1; req_write = 1; req_addr = a; req_len = 3'(len); wr_valid = 0;
        @(negedge clk);
        req_valid = 0; req_addr = 6'($urandom); req_len = 3'($urandom);
        i = 0; t = 0; stalls = 0; g = 0;
        while (i <= len && t < 200) begin
            wr_valid = ($urandom_range(99) >= 32'(stall_pct));
            if (i == 1 && g < gap) begin wr_valid = 0; g++; end
            wr_data = wq[i];
            #1;
            ea = 6'(a + 6'(i));
            chk_cnt++;
            if (o_mem_write !== wr_valid || o_wr_ready !== 1'b1 || o_endereco !== ea ||
                o_mem_read !== 1'b0 || o_done !== 1'b0)
                $display("FAIL store_beat%0d: got we=%b wr_ready=%b addr=%0d rd=%b done=%b exp we=%b wr_ready=1 addr=%0d rd=0 done=0",
                         i, o_mem_write, o_wr_ready, o_endereco, o_mem_read, o_done, wr_valid, ea);
            else pass_cnt++;
            if (wr_valid) begin ref_mem[sel][ea] = wq[i]; i++; end
            else stalls++;
            @(negedge clk); t++;
        end
        wr_valid = 0; #1;
        chk_cnt++;
        if (t !== len + 1 + stalls) $display("FAIL store_cycles: got %0d exp %0d", t, len + 1 + stalls);
        else pass_cnt++;
        chk_cnt++;
        if (o_done !== 1'b1 || o_busy !== 1'b1 || o_mem_write !== 1'b0)
            $display("FAIL store_done: got done=%b busy=%b we=%b exp 1 1 0", o_done, o_busy, o_mem_write);
        else pass_cnt++;
        @(negedge clk); #1;
        chk_cnt++;
        if (o_done !== 1'b0 || o_req_ready !== 1'b1 || o_busy !== 1'b0)
            $display("FAIL store_idle: got done=%b req_ready=%b busy=%b exp 0 1 0", o_done, o_req_ready, o_busy);
        else pass_cnt++;
    endtask

    task automatic do_load(input logic [5:0] a, input int len, input bit noise);
        int lat, n, j;
        bit exp_rv;
        lat = sel + 1; n = len + 1;
        chk_cnt++;
        if (o_req_ready !== 1'b1) $display("FAIL load_req_ready: got %b exp 1", o_req_ready);
        else pass_cnt++;
        req_valid = 1; req_write = 0; req_addr = a; req_len = 3'(len);
        @(negedge clk);
        for (int t = 0; t <= n * lat; t++) begin
            // Requests presented while busy must be ignored.
            req_valid = noise && (t < n * lat) && 1'($urandom);
            req_write = 1'($urandom); req_addr = 6'($urandom); req_len = 3'($urandom);
            #1;
            exp_rv = (t >= lat) && (t % lat == 0);
            j = t / lat - 1;
            chk_cnt++;
            if (o_mem_read !== (t < n * lat) || o_mem_write !== 1'b0 || o_done !== (t == n * lat) ||
                o_rd_valid !== exp_rv || (t < n * lat && o_endereco !== 6'(a + 6'(t / lat))))
                $display("FAIL load_cyc%0d: got rd=%b we=%b done=%b rv=%b addr=%0d exp rd=%b we=0 done=%b rv=%b addr=%0d",
                         t, o_mem_read, o_mem_write, o_done, o_rd_valid, o_endereco,
                         (t < n * lat), (t == n * lat), exp_rv, 6'(a + 6'(t / lat)));
            else pass_cnt++;
            if (exp_rv) begin
                chk_cnt++;
                if (o_rd_data !== ref_mem[sel][6'(a + 6'(j))] || o_rd_last !== (j == len))
                    $display("FAIL load_data%0d: got data=%h last=%b exp data=%h last=%b",
                             j, o_rd_data, o_rd_last, ref_mem[sel][6'(a + 6'(j))], (j == len));
                else pass_cnt++;
            end else if (o_rd_last !== 1'b0) begin
                chk_cnt++;
                $display("FAIL load_last_stray%0d: got %b exp 0", t, o_rd_last);
            end
            @(negedge clk);
        end
        req_valid = 0; #1;
        chk_cnt++;
        if (o_req_ready !== 1'b1 || o_rd_valid !== 1'b0 || o_done !== 1'b0 || o_busy !== 1'b0)
            $display("FAIL load_idle: got req_ready=%b rv=%b done=%b busy=%b exp 1 0 0 0",
                     o_req_ready, o_rd_valid, o_done, o_busy);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        for (int s = 0; s < 2; s++) begin
            chk_cnt++;
            if (req_ready_d[s] !== 1'b1 || busy_d[s] !== 1'b0 || done_d[s] !== 1'b0 ||
                mem_write_d[s] !== 1'b0 || mem_read_d[s] !== 1'b0 || endereco_d[s] !== 6'd0 ||
                wr_ready_d[s] !== 1'b0 || rd_valid_d[s] !== 1'b0 || rd_last_d[s] !== 1'b0 ||
                rd_data_d[s] !== 8'd0)
                $display("FAIL reset_state%0d: got rr=%b busy=%b done=%b we=%b rd=%b addr=%0d wrr=%b rv=%b rl=%b data=%h exp 1 0 0 0 0 0 0 0 0 00",
                         s, req_ready_d[s], busy_d[s], done_d[s], mem_write_d[s], mem_read_d[s],
                         endereco_d[s], wr_ready_d[s], rd_valid_d[s], rd_last_d[s], rd_data_d[s]);
            else pass_cnt++;
        end
    endtask

    task automatic test_fill();
        for (int s = 0; s < 2; s++) begin
            sel = s;
            for (int b = 0; b < 8; b++) begin
                wq.delete();
                for (int k = 0; k < 8; k++) wq.push_back(8'($urandom));
                do_store(6'(b * 8), 7, 0, 0);
            end
        end
    endtask

    task automatic test_store_load();
        sel = 0;
        wq = '{8'hA5, 8'h3C, 8'h7E};
        do_store(6'd10, 2, 0, 0);
        chk_cnt++;
        if (mem[0][10] !== 8'hA5 || mem[0][11] !== 8'h3C || mem[0][12] !== 8'h7E)
            $display("FAIL store_mem: got %h %h %h exp a5 3c 7e", mem[0][10], mem[0][11], mem[0][12]);
        else pass_cnt++;
        do_load(6'd10, 2, 0);
    endtask

    task automatic test_wrap();
        sel = 0;
        wq = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_store(6'd62, 3, 0, 0);
        chk_cnt++;
        if (mem[0][62] !== 8'h11 || mem[0][63] !== 8'h22 || mem[0][0] !== 8'h33 || mem[0][1] !== 8'h44)
            $display("FAIL wrap_mem: got %h %h %h %h exp 11 22 33 44", mem[0][62], mem[0][63], mem[0][0], mem[0][1]);
        else pass_cnt++;
        do_load(6'd62, 3, 0);
    endtask

    task automatic test_stall();
        sel = 0;
        wq = '{8'h5A, 8'hC3};
        do_store(6'd20, 1, 0, 3);
        chk_cnt++;
        if (mem[0][20] !== 8'h5A || mem[0][21] !== 8'hC3)
            $display("FAIL stall_mem: got %h %h exp 5a c3", mem[0][20], mem[0][21]);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        sel = 0;
        wq = '{8'h7E};
        do_store(6'd30, 0, 0, 0);
        req_valid = 1; req_write = 0; req_addr = 6'd40; req_len = 3'd3;
        @(negedge clk); req_valid = 0;
        @(negedge clk);                    // second read beat in progress
        reset = 1; #1;
        chk_cnt++;
        if (o_mem_read !== 1'b0 || o_busy !== 1'b0 || o_mem_write !== 1'b0 || o_endereco !== 6'd0)
            $display("FAIL reset_mid_async: got rd=%b busy=%b we=%b addr=%0d exp 0 0 0 0",
                     o_mem_read, o_busy, o_mem_write, o_endereco);
        else pass_cnt++;
        @(negedge clk); reset = 0;
        for (int t = 0; t < 6; t++) begin
            #1;
            chk_cnt++;
            if (o_done !== 1'b0 || o_rd_valid !== 1'b0 || o_busy !== 1'b0)
                $display("FAIL reset_mid_quiet%0d: got done=%b rv=%b busy=%b exp 0 0 0", t, o_done, o_rd_valid, o_busy);
            else pass_cnt++;
            @(negedge clk);
        end
        do_load(6'd30, 0, 0);
    endtask

    task automatic test_latency2();
        sel = 1;
        wq = '{8'hA5, 8'h3C};
        do_store(6'd10, 1, 0, 0);
        do_load(6'd10, 1, 0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 24; k++) begin
            int len;
            logic [5:0] a;
            sel = k % 2;
            len = $urandom_range(7);
            a = 6'($urandom);
            if ($urandom_range(1) == 1) begin
                wq.delete();
                for (int q = 0; q <= len; q++) wq.push_back(8'($urandom));
                do_store(a, len, 30, 0);
            end else begin
                do_load(a, len, 1);
            end
        end
        for (int s = 0; s < 2; s++) begin
            int bad = 0;
            for (int m = 0; m < 64; m++) if (mem[s][m] !== ref_mem[s][m]) bad++;
            chk_cnt++;
            if (bad != 0) $display("FAIL mem_image%0d: got %0d differing words exp 0", s, bad);
            else pass_cnt++;
        end
    endtask

    initial begin
        reset = 1; sel = 0;
        req_valid = 0; req_write = 0; req_addr = 0; req_len = 0; wr_valid = 0; wr_data = 0;
        #1;
        test_reset();
        #20;
        @(negedge clk); reset = 0;
        test_fill();
        test_store_load();
        test_wrap();
        test_stall();
        test_reset_mid();
        test_latency2();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish exp finish");
        $fatal(1);
    end

endmodule
